// File: rtl/act_pkg.sv
// Shared types and constants for the activation-function datapath.
// Operands are signed Q1.6 and exponential results are unsigned Q3.5.
package act_pkg;

  localparam int SZ           = 8;
  localparam int EXP_IN_FRAC  = 6;
  localparam int EXP_OUT_FRAC = 5;

  typedef logic signed [EXP_IN_FRAC+1:0] exp_arg_t;  // Q1.6 operand
  typedef logic        [EXP_OUT_FRAC+2:0] exp_val_t; // Q3.5 result

endpackage

// File: rtl/exp_rom.sv
// Combinational e^x table: val = round_half_up(exp(signed(addr)/64) * 32).
// The contents were generated offline and are monotonic in signed address order.
module exp_rom
  import act_pkg::*;
(
  input  logic [SZ-1:0] addr,
  output exp_val_t      val
);

  always_comb begin
    val = '0;
    case (addr)
      8'h00: val = 8'd32;   8'h01: val = 8'd33;
      8'h02: val = 8'd33;   8'h03: val = 8'd34;
      8'h04: val = 8'd34;   8'h05: val = 8'd35;
      8'h06: val = 8'd35;   8'h07: val = 8'd36;
      8'h08: val = 8'd36;   8'h09: val = 8'd37;
      8'h0A: val = 8'd37;   8'h0B: val = 8'd38;
      8'h0C: val = 8'd39;   8'h0D: val = 8'd39;
      8'h0E: val = 8'd40;   8'h0F: val = 8'd40;
      8'h10: val = 8'd41;   8'h11: val = 8'd42;
      8'h12: val = 8'd42;   8'h13: val = 8'd43;
      8'h14: val = 8'd44;   8'h15: val = 8'd44;
      8'h16: val = 8'd45;   8'h17: val = 8'd46;
      8'h18: val = 8'd47;   8'h19: val = 8'd47;
      8'h1A: val = 8'd48;   8'h1B: val = 8'd49;
      8'h1C: val = 8'd50;   8'h1D: val = 8'd50;
      8'h1E: val = 8'd51;   8'h1F: val = 8'd52;
      8'h20: val = 8'd53;   8'h21: val = 8'd54;
      8'h22: val = 8'd54;   8'h23: val = 8'd55;
      8'h24: val = 8'd56;   8'h25: val = 8'd57;
      8'h26: val = 8'd58;   8'h27: val = 8'd59;
      8'h28: val = 8'd60;   8'h29: val = 8'd61;
      8'h2A: val = 8'd62;   8'h2B: val = 8'd63;
      8'h2C: val = 8'd64;   8'h2D: val = 8'd65;
      8'h2E: val = 8'd66;   8'h2F: val = 8'd67;
      8'h30: val = 8'd68;   8'h31: val = 8'd69;
      8'h32: val = 8'd70;   8'h33: val = 8'd71;
      8'h34: val = 8'd72;   8'h35: val = 8'd73;
      8'h36: val = 8'd74;   8'h37: val = 8'd76;
      8'h38: val = 8'd77;   8'h39: val = 8'd78;
      8'h3A: val = 8'd79;   8'h3B: val = 8'd80;
      8'h3C: val = 8'd82;   8'h3D: val = 8'd83;
      8'h3E: val = 8'd84;   8'h3F: val = 8'd86;
      8'h40: val = 8'd87;   8'h41: val = 8'd88;
      8'h42: val = 8'd90;   8'h43: val = 8'd91;
      8'h44: val = 8'd93;   8'h45: val = 8'd94;
      8'h46: val = 8'd96;   8'h47: val = 8'd97;
      8'h48: val = 8'd99;   8'h49: val = 8'd100;
      8'h4A: val = 8'd102;  8'h4B: val = 8'd103;
      8'h4C: val = 8'd105;  8'h4D: val = 8'd107;
      8'h4E: val = 8'd108;  8'h4F: val = 8'd110;
      8'h50: val = 8'd112;  8'h51: val = 8'd113;
      8'h52: val = 8'd115;  8'h53: val = 8'd117;
      8'h54: val = 8'd119;  8'h55: val = 8'd121;
      8'h56: val = 8'd123;  8'h57: val = 8'd125;
      8'h58: val = 8'd127;  8'h59: val = 8'd129;
      8'h5A: val = 8'd131;  8'h5B: val = 8'd133;
      8'h5C: val = 8'd135;  8'h5D: val = 8'd137;
      8'h5E: val = 8'd139;  8'h5F: val = 8'd141;
      8'h60: val = 8'd143;  8'h61: val = 8'd146;
      8'h62: val = 8'd148;  8'h63: val = 8'd150;
      8'h64: val = 8'd153;  8'h65: val = 8'd155;
      8'h66: val = 8'd158;  8'h67: val = 8'd160;
      8'h68: val = 8'd163;  8'h69: val = 8'd165;
      8'h6A: val = 8'd168;  8'h6B: val = 8'd170;
      8'h6C: val = 8'd173;  8'h6D: val = 8'd176;
      8'h6E: val = 8'd178;  8'h6F: val = 8'd181;
      8'h70: val = 8'd184;  8'h71: val = 8'd187;
      8'h72: val = 8'd190;  8'h73: val = 8'd193;
      8'h74: val = 8'd196;  8'h75: val = 8'd199;
      8'h76: val = 8'd202;  8'h77: val = 8'd205;
      8'h78: val = 8'd209;  8'h79: val = 8'd212;
      8'h7A: val = 8'd215;  8'h7B: val = 8'd219;
      8'h7C: val = 8'd222;  8'h7D: val = 8'd226;
      8'h7E: val = 8'd229;  8'h7F: val = 8'd233;
      // Negative operands: 0x80 is -2.0, 0xFF is -1/64.
      8'h80: val = 8'd4;    8'h81: val = 8'd4;
      8'h82: val = 8'd4;    8'h83: val = 8'd5;
      8'h84: val = 8'd5;    8'h85: val = 8'd5;
      8'h86: val = 8'd5;    8'h87: val = 8'd5;
      8'h88: val = 8'd5;    8'h89: val = 8'd5;
      8'h8A: val = 8'd5;    8'h8B: val = 8'd5;
      8'h8C: val = 8'd5;    8'h8D: val = 8'd5;
      8'h8E: val = 8'd5;    8'h8F: val = 8'd5;
      8'h90: val = 8'd6;    8'h91: val = 8'd6;
      8'h92: val = 8'd6;    8'h93: val = 8'd6;
      8'h94: val = 8'd6;    8'h95: val = 8'd6;
      8'h96: val = 8'd6;    8'h97: val = 8'd6;
      8'h98: val = 8'd6;    8'h99: val = 8'd6;
      8'h9A: val = 8'd7;    8'h9B: val = 8'd7;
      8'h9C: val = 8'd7;    8'h9D: val = 8'd7;
      8'h9E: val = 8'd7;    8'h9F: val = 8'd7;
      8'hA0: val = 8'd7;    8'hA1: val = 8'd7;
      8'hA2: val = 8'd7;    8'hA3: val = 8'd7;
      8'hA4: val = 8'd8;    8'hA5: val = 8'd8;
      8'hA6: val = 8'd8;    8'hA7: val = 8'd8;
      8'hA8: val = 8'd8;    8'hA9: val = 8'd8;
      8'hAA: val = 8'd8;    8'hAB: val = 8'd8;
      8'hAC: val = 8'd9;    8'hAD: val = 8'd9;
      8'hAE: val = 8'd9;    8'hAF: val = 8'd9;
      8'hB0: val = 8'd9;    8'hB1: val = 8'd9;
      8'hB2: val = 8'd9;    8'hB3: val = 8'd10;
      8'hB4: val = 8'd10;   8'hB5: val = 8'd10;
      8'hB6: val = 8'd10;   8'hB7: val = 8'd10;
      8'hB8: val = 8'd10;   8'hB9: val = 8'd11;
      8'hBA: val = 8'd11;   8'hBB: val = 8'd11;
      8'hBC: val = 8'd11;   8'hBD: val = 8'd11;
      8'hBE: val = 8'd11;   8'hBF: val = 8'd12;
      8'hC0: val = 8'd12;   8'hC1: val = 8'd12;
      8'hC2: val = 8'd12;   8'hC3: val = 8'd12;
      8'hC4: val = 8'd13;   8'hC5: val = 8'd13;
      8'hC6: val = 8'd13;   8'hC7: val = 8'd13;
      8'hC8: val = 8'd13;   8'hC9: val = 8'd14;
      8'hCA: val = 8'd14;   8'hCB: val = 8'd14;
      8'hCC: val = 8'd14;   8'hCD: val = 8'd14;
      8'hCE: val = 8'd15;   8'hCF: val = 8'd15;
      8'hD0: val = 8'd15;   8'hD1: val = 8'd15;
      8'hD2: val = 8'd16;   8'hD3: val = 8'd16;
      8'hD4: val = 8'd16;   8'hD5: val = 8'd16;
      8'hD6: val = 8'd17;   8'hD7: val = 8'd17;
      8'hD8: val = 8'd17;   8'hD9: val = 8'd17;
      8'hDA: val = 8'd18;   8'hDB: val = 8'd18;
      8'hDC: val = 8'd18;   8'hDD: val = 8'd19;
      8'hDE: val = 8'd19;   8'hDF: val = 8'd19;
      8'hE0: val = 8'd19;   8'hE1: val = 8'd20;
      8'hE2: val = 8'd20;   8'hE3: val = 8'd20;
      8'hE4: val = 8'd21;   8'hE5: val = 8'd21;
      8'hE6: val = 8'd21;   8'hE7: val = 8'd22;
      8'hE8: val = 8'd22;   8'hE9: val = 8'd22;
      8'hEA: val = 8'd23;   8'hEB: val = 8'd23;
      8'hEC: val = 8'd23;   8'hED: val = 8'd24;
      8'hEE: val = 8'd24;   8'hEF: val = 8'd25;
      8'hF0: val = 8'd25;   8'hF1: val = 8'd25;
      8'hF2: val = 8'd26;   8'hF3: val = 8'd26;
      8'hF4: val = 8'd27;   8'hF5: val = 8'd27;
      8'hF6: val = 8'd27;   8'hF7: val = 8'd28;
      8'hF8: val = 8'd28;   8'hF9: val = 8'd29;
      8'hFA: val = 8'd29;   8'hFB: val = 8'd30;
      8'hFC: val = 8'd30;   8'hFD: val = 8'd31;
      8'hFE: val = 8'd31;   8'hFF: val = 8'd32;
      default: val = '0;
    endcase
  end

endmodule

// File: rtl/exp_lut.sv
// Registered e^x look-up: one-cycle latency, one result per cycle.
// The output register only loads on in_valid, so idle operand bits never reach exp.
module exp_lut #(
  parameter int SZ = act_pkg::SZ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [SZ-1:0] angle,
  output logic          out_valid,
  output logic [SZ-1:0] exp
);
  import act_pkg::*;

  localparam int IN_FRAC  = EXP_IN_FRAC;
  localparam int OUT_FRAC = EXP_OUT_FRAC;

  logic signed [IN_FRAC+1:0] angle_s;
  logic [OUT_FRAC+2:0]       rom_val;
  exp_val_t                  exp_d, exp_q;
  logic                      valid_d, valid_q;

  assign angle_s = angle;

  exp_rom u_rom (
    .addr (angle_s),
    .val  (rom_val)
  );

  always_comb begin
    exp_d   = exp_q;
    valid_d = 1'b0;
    if (in_valid) begin
      exp_d   = rom_val;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      valid_q <= valid_d;
    end
  end

  assign exp       = exp_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_exp_lut.sv
// Self-checking bench for exp_lut: a floating-point e^x model checked every cycle,
// plus hand-computed anchor values at fixed points of the directed sequence.
module tb_exp_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] angle;
  logic       out_valid;
  logic [7:0] exp_o;

  int n_checks = 0;
  int n_fail   = 0;

  int   m_exp   = 0;
  logic m_valid = 1'b0;
  logic m_ready = 1'b0;

  exp_lut #(.SZ(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .angle     (angle),
    .out_valid (out_valid),
    .exp       (exp_o)
  );

  always #5 clk = ~clk;

  function automatic int golden(input logic [7:0] a);
    int  s;
    real r;
    s = int'($signed(a));
    r = $exp(real'(s) / 64.0) * 32.0 + 0.5;
    return int'($floor(r));
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // Drive one operand from a falling edge; returns on the next falling edge.
  task automatic apply(input logic r, input logic v, input logic [7:0] a);
    rst      = r;
    in_valid = v;
    angle    = a;
    @(negedge clk);
    $display("txn rst=%0b vld=%0b angle=%02h -> out_valid=%0b exp=%02h", r, v, a, out_valid, exp_o);
  endtask

  // Reference behaviour: result is e^angle one cycle later, held while idle, cleared by reset.
  always @(posedge clk) begin
    if (rst) begin
      m_exp   <= 0;
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end else if (in_valid) begin
      m_exp   <= golden(angle);
      m_valid <= 1'b1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("model_valid", int'(out_valid), int'(m_valid));
      check("model_exp", int'(exp_o), m_exp);
    end
  end

  logic [7:0] anc_in  [6] = '{8'h00, 8'h40, 8'hC0, 8'h80, 8'h7F, 8'h20};
  logic [7:0] anc_out [6] = '{8'h20, 8'h57, 8'h0C, 8'h04, 8'hE9, 8'h35};

  initial begin
    int prev;
    rst      = 1'b1;
    in_valid = 1'b1;
    angle    = 8'h40;

    repeat (3) begin
      apply(1'b1, 1'b1, 8'h40);
      check("reset_exp", int'(exp_o), 0);
      check("reset_valid", int'(out_valid), 0);
    end
    apply(1'b0, 1'b1, 8'h40);
    check("first_exp", int'(exp_o), 8'h57);
    check("first_valid", int'(out_valid), 1);

    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b1, anc_in[k]);
      check("anchor_exp", int'(exp_o), int'(anc_out[k]));
      check("anchor_valid", int'(out_valid), 1);
    end

    prev = -1;
    for (int i = -180; i < 180; i++) begin
      apply(1'b0, 1'b1, 8'((i * 256) / 360));
      if (prev >= 0)
        check("sweep_monotonic", int'(int'(exp_o) >= prev), 1);
      prev = int'(exp_o);
    end

    for (int a = 0; a < 256; a++)
      apply(1'b0, 1'b1, 8'(a));

    apply(1'b0, 1'b1, 8'h40);
    check("idle_load", int'(exp_o), 8'h57);
    repeat (5) begin
      apply(1'b0, 1'b0, 8'($urandom));
      check("idle_hold_exp", int'(exp_o), 8'h57);
      check("idle_valid", int'(out_valid), 0);
    end

    apply(1'b0, 1'b1, 8'h10);
    apply(1'b0, 1'b1, 8'h20);
    apply(1'b1, 1'b1, 8'h30);
    check("midrst_exp", int'(exp_o), 0);
    check("midrst_valid", int'(out_valid), 0);
    apply(1'b0, 1'b1, 8'h7F);
    check("resume_exp", int'(exp_o), 8'hE9);
    check("resume_valid", int'(out_valid), 1);
    apply(1'b0, 1'b1, 8'hC0);
    check("resume_exp2", int'(exp_o), 8'h0C);
    apply(1'b0, 1'b0, 8'h00);
    check("tail_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/exp_lut.md
Name: exp_lut

Overview:
- Registered 256-entry look-up table that computes e^x for an 8-bit signed fixed-point operand.
- Used as the exponential stage of the activation-function datapath (softmax/sigmoid front ends).
- Pure ROM plus one pipeline register; no arithmetic is performed at run time.

Parameters:
- SZ, 8, data width of `angle` and `exp`. Only 8 is supported because the table contents are fixed.
- IN_FRAC (localparam), 6, fractional bits of `angle`. Not overridable.
- OUT_FRAC (localparam), 5, fractional bits of `exp`. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies `angle` this cycle.
- angle  input  SZ  operand x, two's-complement signed Q1.6; range -2.0 (0x80) to +1.984375 (0x7F).
- out_valid  output  1  registered; high one cycle after an accepted input.
- exp  output  SZ  e^x, unsigned Q3.5; range 0 to 7.96875.

Behaviour:
- Table definition:
  - entry[a] = floor(exp(s/64) * 32 + 0.5), where s is `a` interpreted as a signed 8-bit value.
  - Rounding is to nearest, half up.
  - All 256 entries fall within 4..233, so no saturation or clamping is needed.
  - The table is monotonic non-decreasing in signed order.
- Anchor entries:
  - 0x80 -> 0x04
  - 0xC0 -> 0x0C
  - 0x00 -> 0x20
  - 0x20 -> 0x35
  - 0x40 -> 0x57
  - 0x7F -> 0xE9
- Latency is 1 cycle. At the rising edge with in_valid=1, exp <= entry[angle] and out_valid <= 1.
- When in_valid=0 at an edge:
  - out_valid <= 0.
  - exp holds its previous value (no data toggling when idle).
- Throughput: one result per cycle. There is no backpressure and no busy state.
- Reset:
  - While rst=1 at an edge: exp <= 0x00 and out_valid <= 0.
  - rst takes precedence over a simultaneous in_valid.
  - An operand presented in the same cycle as reset is discarded.
  - The first valid result appears one cycle after the first in_valid edge following rst deassertion.
- The output is a pure function of the registered input index; there is no history dependence.
- X or undefined `angle` bits while in_valid=0 must not propagate to exp.
- There is no state machine; the only state is the output register and the valid flag.

Decomposition:
- Shared package `act_pkg` holds:
  - SZ
  - the EXP_IN_FRAC and EXP_OUT_FRAC constants
  - a typedef for the signed Q1.6 operand
  - a typedef for the unsigned Q3.5 result
- Sub-module `exp_rom`:
  - purely combinational 256-way case table with 8-bit in and 8-bit out.
  - Generated offline from the formula above; this accounts for most of the RTL line count.
- The top level, exp_lut, contains only the valid/output register and the reset logic around `exp_rom`.

Test Plan:
- Reset check:
  - Hold rst=1 for 3 cycles with in_valid=1 and angle=0x40.
  - Required: exp=0x00 and out_valid=0 throughout.
  - Then release rst; the next accepted input 0x40 gives exp=0x57 one cycle later.
- Anchor points, issued back-to-back with in_valid=1:
  - Input sequence 0x00, 0x40, 0xC0, 0x80, 0x7F, 0x20.
  - Required outputs, each 1 cycle later: 0x20, 0x57, 0x0C, 0x04, 0xE9, 0x35.
  - out_valid stays high continuously.
- Signed sweep:
  - For i = -180 to 179, angle = trunc_toward_zero(256*i/360) taken mod 256.
  - Each output must match the golden formula exactly.
  - Consecutive outputs must be non-decreasing.
- Exhaustive:
  - Apply all 256 codes.
  - Compare against a floating-point reference with zero tolerance on the rounded value.
- Idle hold:
  - Send 0x40, then drop in_valid and wiggle angle randomly for 5 cycles.
  - Required: exp stays 0x57 and out_valid=0 during the idle cycles.
- Reset mid-stream:
  - Assert rst for 1 cycle during a back-to-back stream.
  - Required: the output register clears to 0x00 with out_valid=0 on that edge.
  - The stream resumes correctly on the following cycles.
